// File: rtl/carrier_seq_ctrl.sv
// Carrier sequencer: divides the clock into carrier sample strobes, steps a
// 2-bit carrier phase with advance/retard nudges from a tracking loop, emits
// quadrature samples from a 4-entry LUT and stops on a completed carrier period.
module carrier_seq_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned SYM_LEN = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_adv,
  input  logic              i_ret,
  output logic              o_busy,
  output logic              o_strobe,
  output logic [1:0]        o_phase,
  output logic signed [3:0] o_cos,
  output logic signed [3:0] o_sin,
  output logic              o_sym_tick,
  output logic              o_done
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] SAMP_LAST = 8'(SYM_LEN - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic [7:0] samp_cnt_q, samp_cnt_d;
  logic [1:0] phase_q, phase_d;
  logic       adv_pend_q, adv_pend_d;
  logic       ret_pend_q, ret_pend_d;
  logic       done_q, done_d;

  logic       busy;
  logic       strobe;
  logic       adv_eff;
  logic       ret_eff;
  logic       retarded;
  logic [1:0] phase_step;
  logic       stop_exit;

  // Carrier sample table: cos uses phase, sin lags it by one quarter period.
  function automatic logic signed [3:0] carrier_lut(input logic [1:0] p);
    case (p)
      2'd0:    carrier_lut = 4'sd7;
      2'd2:    carrier_lut = -4'sd7;
      default: carrier_lut = 4'sd0;
    endcase
  endfunction

  // Strobe timing and the phase step that the current strobe would apply.
  always_comb begin
    busy     = (state_q == ST_RUN) || (state_q == ST_STOPPING);
    strobe   = busy && (div_cnt_q == DIV_LAST);
    // A request arriving in the strobe cycle itself still counts for that strobe.
    adv_eff  = adv_pend_q | i_adv;
    ret_eff  = ret_pend_q | i_ret;
    retarded = ret_eff && !adv_eff;
    if (adv_eff && !ret_eff) begin
      phase_step = 2'd2;
    end else if (retarded) begin
      phase_step = 2'd0;
    end else begin
      phase_step = 2'd1;
    end
    // A retarded phase-3 strobe repeats phase 3, so the period is not complete yet.
    stop_exit = (state_q == ST_STOPPING) && strobe && (phase_q == 2'd3) && !retarded;
  end

  // Next-state logic for the FSM, counters and pending nudge flags.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    samp_cnt_d = samp_cnt_q;
    phase_d    = phase_q;
    adv_pend_d = adv_pend_q;
    ret_pend_d = ret_pend_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_stop) begin
          state_d    = ST_RUN;
          div_cnt_d  = '0;
          samp_cnt_d = '0;
          phase_d    = '0;
          adv_pend_d = 1'b0;
          ret_pend_d = 1'b0;
        end
      end
      ST_RUN, ST_STOPPING: begin
        if (strobe) begin
          div_cnt_d  = '0;
          phase_d    = phase_q + phase_step;
          samp_cnt_d = (samp_cnt_q == SAMP_LAST) ? 8'd0 : samp_cnt_q + 8'd1;
          adv_pend_d = 1'b0;
          ret_pend_d = 1'b0;
        end else begin
          div_cnt_d  = div_cnt_q + 8'd1;
          adv_pend_d = adv_pend_q | i_adv;
          ret_pend_d = ret_pend_q | i_ret;
        end
        if ((state_q == ST_RUN) && i_stop) begin
          state_d = ST_STOPPING;
        end
        if (stop_exit) begin
          state_d    = ST_IDLE;
          div_cnt_d  = '0;
          samp_cnt_d = '0;
          phase_d    = '0;
          done_d     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      samp_cnt_q <= '0;
      phase_q    <= '0;
      adv_pend_q <= 1'b0;
      ret_pend_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      phase_q    <= phase_d;
      adv_pend_q <= adv_pend_d;
      ret_pend_q <= ret_pend_d;
      done_q     <= done_d;
    end
  end

  // Outputs decoded from registered state; samples forced to zero in IDLE.
  always_comb begin
    o_busy     = busy;
    o_strobe   = strobe;
    o_phase    = phase_q;
    o_cos      = busy ? carrier_lut(phase_q) : 4'sd0;
    o_sin      = busy ? carrier_lut(phase_q - 2'd1) : 4'sd0;
    o_sym_tick = strobe && (samp_cnt_q == SAMP_LAST);
    o_done     = done_q;
  end

endmodule

// File: tb/tb_carrier_seq_ctrl.sv
// Scoreboard bench for carrier_seq_ctrl (CLK_DIV=4, SYM_LEN=8): stimulus pushes
// expected strobes and done pulses; a negedge monitor pops and compares them.
module tb_carrier_seq_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, stop, adv, ret;
  logic              busy, strobe, sym_tick, done;
  logic [1:0]        phase;
  logic signed [3:0] cos_s, sin_s;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 0;

  typedef struct {
    int cyc;
    int ph;
    int cs;
    int sn;
    int tk;
  } exp_t;

  exp_t sq[$];
  int   dq[$];
  exp_t me;
  int   md;

  carrier_seq_ctrl #(
    .CLK_DIV(4),
    .SYM_LEN(8)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_stop     (stop),
    .i_adv      (adv),
    .i_ret      (ret),
    .o_busy     (busy),
    .o_strobe   (strobe),
    .o_phase    (phase),
    .o_cos      (cos_s),
    .o_sin      (sin_s),
    .o_sym_tick (sym_tick),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc - base);
    end
  endtask

  function automatic int lut(input int p);
    case (p)
      0:       return 7;
      2:       return -7;
      default: return 0;
    endcase
  endfunction

  function automatic void push_s(input int c, input int ph, input int tk);
    exp_t e;
    e.cyc = c;
    e.ph  = ph;
    e.cs  = lut(ph);
    e.sn  = lut((ph + 3) % 4);
    e.tk  = tk;
    sq.push_back(e);
  endfunction

  // Monitor: every strobe and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (strobe) begin
      if (sq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got strobe phase=%0d at cycle %0d expected none",
                 phase, cyc - base);
      end else begin
        me = sq.pop_front();
        chk("strobe_cycle", cyc - base, me.cyc);
        chk("strobe_phase", int'(phase), me.ph);
        chk("strobe_cos", int'(cos_s), me.cs);
        chk("strobe_sin", int'(sin_s), me.sn);
        chk("strobe_sym_tick", int'(sym_tick), me.tk);
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc - base);
      end else begin
        md = dq.pop_front();
        chk("done_cycle", cyc - base, md);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int n);
    while (cyc < base + n) tick();
  endtask

  // Drive the given inputs during relative cycle n for exactly one cycle.
  task automatic drive_at(input int n, input logic st, input logic sp, input logic ad,
                          input logic rt);
    wait_to(n);
    start = st;
    stop  = sp;
    adv   = ad;
    ret   = rt;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    adv   = 1'b0;
    ret   = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_strobe"}, int'(strobe), 0);
    chk({tag, "_phase"}, int'(phase), 0);
    chk({tag, "_cos"}, int'(cos_s), 0);
    chk({tag, "_sin"}, int'(sin_s), 0);
    chk({tag, "_sym_tick"}, int'(sym_tick), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  task automatic drain(input int n);
    wait_to(n);
    chk("strobe_queue_empty", sq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    sq.delete();
    dq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    adv   = 1'b0;
    ret   = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // Start together with stop in IDLE: stop wins, stays idle.
    base = cyc;
    drive_at(0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("start_stop_idle_busy", int'(busy), 0);
    tick();

    // Long run: plain phase rotation, symbol ticks on strobes 8 and 16, then stop.
    base = cyc;
    for (int k = 1; k <= 16; k++) push_s(4 * k, (k - 1) % 4, (k % 8 == 0) ? 1 : 0);
    push_s(68, 0, 0);
    push_s(72, 1, 0);
    push_s(76, 2, 0);
    push_s(80, 3, 0);
    dq.push_back(81);
    drive_at(0, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_to(30);
    chk("run_busy", int'(busy), 1);
    drive_at(66, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_to(82);
    chk("after_stop_busy", int'(busy), 0);
    chk("after_stop_cos", int'(cos_s), 0);
    drain(86);

    // Stop at cycle 6; a start while busy is ignored.
    base = cyc;
    push_s(4, 0, 0);
    push_s(8, 1, 0);
    push_s(12, 2, 0);
    push_s(16, 3, 0);
    dq.push_back(17);
    drive_at(0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_at(6, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_at(10, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_to(16);
    chk("stopping_busy", int'(busy), 1);
    wait_to(17);
    chk("idle_busy_17", int'(busy), 0);
    drain(22);

    // Advance at 5, then advance+retard together at 18 cancel to a +1 step.
    base = cyc;
    push_s(4, 0, 0);
    push_s(8, 1, 0);
    push_s(12, 3, 0);
    push_s(16, 0, 0);
    push_s(20, 1, 0);
    push_s(24, 2, 0);
    push_s(28, 3, 0);
    dq.push_back(29);
    drive_at(0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_at(5, 1'b0, 1'b0, 1'b1, 1'b0);
    drive_at(18, 1'b0, 1'b0, 1'b1, 1'b1);
    drive_at(25, 1'b0, 1'b1, 1'b0, 1'b0);
    drain(34);

    // Retard in strobe cycle 8; a retarded phase-3 strobe while stopping delays exit.
    base = cyc;
    push_s(4, 0, 0);
    push_s(8, 1, 0);
    push_s(12, 1, 0);
    push_s(16, 2, 0);
    push_s(20, 3, 0);
    push_s(24, 3, 0);
    dq.push_back(25);
    drive_at(0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_at(8, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_at(14, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_at(20, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_to(22);
    chk("retarded_exit_busy", int'(busy), 1);
    wait_to(25);
    chk("retarded_exit_idle", int'(busy), 0);
    drain(30);

    // Reset mid-run at cycle 10: outputs clear, no done, then a clean restart.
    base = cyc;
    push_s(4, 0, 0);
    push_s(8, 1, 0);
    drive_at(0, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_to(10);
    rst_n = 1'b0;
    tick();
    chk_zero("mid_reset");
    rst_n = 1'b1;
    tick();
    drain(16);

    base = cyc;
    push_s(4, 0, 0);
    push_s(8, 1, 0);
    push_s(12, 2, 0);
    push_s(16, 3, 0);
    dq.push_back(17);
    drive_at(0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_at(9, 1'b0, 1'b1, 1'b0, 1'b0);
    drain(22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/carrier_seq_ctrl.md
CARRIER_SEQ_CTRL -- requirements
Module: carrier_seq_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: clocks per carrier sample, legal range 2..255.
REQ-002 The block SHALL have parameter SYM_LEN, default 8: carrier samples per symbol, legal range 2..255.
REQ-003 The block SHALL have port i_clk, input, 1 bit: clock, all logic on the rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port i_start, input, 1 bit: start carrier generation, sampled in IDLE only.
REQ-006 The block SHALL have port i_stop, input, 1 bit: request graceful stop.
REQ-007 The block SHALL have port i_adv, input, 1 bit: phase-advance request pulse from the tracking loop.
REQ-008 The block SHALL have port i_ret, input, 1 bit: phase-retard request pulse from the tracking loop.
REQ-009 The block SHALL have port o_busy, output, 1 bit: high in RUN or STOPPING.
REQ-010 The block SHALL have port o_strobe, output, 1 bit: one-cycle sample strobe.
REQ-011 The block SHALL have port o_phase, output, 2 bits: current carrier phase index.
REQ-012 The block SHALL have port o_cos, output, signed 4 bits: in-phase carrier sample.
REQ-013 The block SHALL have port o_sin, output, signed 4 bits: quadrature carrier sample.
REQ-014 The block SHALL have port o_sym_tick, output, 1 bit: pulses with the last strobe of each symbol.
REQ-015 The block SHALL have port o_done, output, 1 bit: one-cycle pulse on return to IDLE after a stop.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and STOPPING.
REQ-017 In IDLE with i_start=1 and i_stop=0, the FSM SHALL go to RUN with div_cnt=0, phase=0, samp_cnt=0 and both pending flags cleared; i_stop has priority, and IDLE with i_start=i_stop=1 SHALL stay in IDLE.
REQ-018 In RUN and STOPPING, div_cnt SHALL count 0..CLK_DIV-1 and wrap to 0.
REQ-019 o_strobe SHALL be 1 exactly in the cycles where div_cnt==CLK_DIV-1, so the first strobe occurs CLK_DIV cycles after the cycle in which i_start was sampled and strobes repeat every CLK_DIV cycles.
REQ-020 o_cos SHALL equal LUT[phase] and o_sin SHALL equal LUT[(phase-1) mod 4], with LUT = {0:+7, 1:0, 2:-7, 3:0}; both SHALL be valid while o_strobe=1, and both SHALL be 0 in IDLE.
REQ-021 Flag adv_pend SHALL be set by i_adv and ret_pend by i_ret in RUN or STOPPING; a request in a strobe cycle SHALL apply to that strobe, and both flags SHALL clear at every strobe.
REQ-022 At each strobe, phase SHALL update by +2 if only adv is effective, +0 if only ret is effective, and +1 otherwise (including when both are effective, which cancel); the addition SHALL be mod 4 with 2-bit wrap.
REQ-023 samp_cnt SHALL increment at each strobe and wrap at SYM_LEN-1 to 0.
REQ-024 o_sym_tick SHALL equal o_strobe AND (samp_cnt==SYM_LEN-1).
REQ-025 i_stop in RUN SHALL move the FSM to STOPPING; strobes SHALL continue in STOPPING.
REQ-026 In STOPPING, the FSM SHALL go to IDLE after the strobe emitted with phase==3 (carrier period completed).
REQ-027 If the FSM is in STOPPING and phase==3 but the strobe is retarded, the block SHALL keep running until a strobe with phase==3 is actually emitted.
REQ-028 o_done SHALL pulse for 1 cycle, in the first IDLE cycle after STOPPING.
REQ-029 i_start outside IDLE SHALL be ignored, i_stop in IDLE or STOPPING SHALL be ignored, and i_adv/i_ret in IDLE SHALL be ignored.
REQ-030 o_busy SHALL be high in RUN or STOPPING.
REQ-031 o_phase SHALL show the phase register.

Reset
REQ-032 While i_rst_n=0 at a clock edge, the block SHALL set state=IDLE, div_cnt=0, samp_cnt=0, phase=0 and pending flags=0.
REQ-033 While i_rst_n=0 at a clock edge, all outputs SHALL be 0.
REQ-034 A reset asserted mid-RUN or mid-STOPPING SHALL abort immediately, with no o_done pulse.

Verification (CLK_DIV=4, SYM_LEN=8)
REQ-035 The bench SHALL cover: i_start at cycle 0 -> strobes at cycles 4,8,12,16 with o_cos=+7,0,-7,0 and o_sin=0,+7,0,-7.
REQ-036 The bench SHALL cover: 8 strobes after start -> o_sym_tick only on the 8th strobe (cycle 32), then on the 16th strobe.
REQ-037 The bench SHALL cover: i_adv pulse at cycle 5 -> strobe at cycle 8 shows phase 1, strobe at cycle 12 shows phase 3; i_adv and i_ret both pulsed before one strobe -> normal +1 step.
REQ-038 The bench SHALL cover: i_ret in the strobe cycle at cycle 8 -> strobe at cycle 12 repeats the phase of cycle 8 (o_cos=0).
REQ-039 The bench SHALL cover: i_stop at cycle 6 -> strobes continue through cycle 16 (phase 3), IDLE at cycle 17, o_done=1 at cycle 17 only, o_busy=0 from cycle 17.
REQ-040 The bench SHALL cover: i_rst_n=0 at cycle 10 during RUN -> next cycle all outputs 0, o_done never pulses, and a fresh i_start restarts the sequence at phase 0.
